// File: rtl/wb_regfile.sv
// Writeback stage and 16-entry architectural register file with a main write
// port, an R0 side-result port, write-through bypassed reads and a commit counter.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_dm,
  input  logic [DATA_W-1:0] wb_ALU,
  input  logic [DATA_W-1:0] wb_R0,
  input  logic [ADDR_W-1:0] wb_wAddr,
  input  logic              wb_muxWB,
  input  logic              wb_regWrite,
  input  logic              wb_regWrite0,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2,
  output logic [DATA_W-1:0] rDataR0,
  output logic [DATA_W-1:0] wbData,
  output logic [15:0]       wbCount
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [15:0]       count_q;
  logic              wr_main;
  logic              wr_r0;

  // Bypass paths are gated by reset so every read port reads zero while held.
  assign wr_main = reset & wb_regWrite;
  assign wr_r0   = reset & wb_regWrite0;

  // NOTE: always_comb with a value on every path; a missing else would infer a latch.
  always_comb begin
    wbData = '0;
    if (reset) wbData = wb_muxWB ? wb_dm : wb_ALU;
  end

  // Main port has priority over the R0 port, matching the write collision rule.
  assign rData1  = (wr_main && rAddr1 == wb_wAddr) ? wbData :
                   (wr_r0 && rAddr1 == '0)         ? wb_R0  : regs[rAddr1];
  assign rData2  = (wr_main && rAddr2 == wb_wAddr) ? wbData :
                   (wr_r0 && rAddr2 == '0)         ? wb_R0  : regs[rAddr2];
  assign rDataR0 = (wr_main && wb_wAddr == '0)     ? wbData :
                   wr_r0                           ? wb_R0  : regs[0];

  assign wbCount = count_q;

  // NOTE: the array is reset explicitly because the ISA defines all registers as zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking writes; the later main-port write to reg0 wins a collision.
      if (wb_regWrite0) regs[0] <= wb_R0;
      if (wb_regWrite)  regs[wb_wAddr] <= wbData;
      if (wb_regWrite | wb_regWrite0) count_q <= count_q + 16'd1;
    end
  end

endmodule
